// File: rtl/tcs3502_poll_ctrl.sv
// tcs3502_poll_ctrl: sequences TCS3502 enable write and periodic 8-byte colour reads over a byte-level I2C master
module tcs3502_poll_ctrl #(
    parameter logic [6:0]  DEV_ADDR    = 7'h29,
    parameter logic [7:0]  REG_ENABLE  = 8'h00,
    parameter logic [7:0]  ENABLE_VAL  = 8'h03,
    parameter logic [7:0]  REG_DATA    = 8'h14,
    parameter int unsigned POLL_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        i2c_cmd_valid,
    input  logic        i2c_cmd_ready,
    output logic        i2c_cmd_rw,
    output logic [6:0]  i2c_cmd_addr,
    output logic [7:0]  i2c_cmd_reg,
    output logic [7:0]  i2c_cmd_wdata,
    input  logic        i2c_rsp_valid,
    input  logic        i2c_rsp_nack,
    input  logic [7:0]  i2c_rsp_rdata,
    output logic [15:0] clear_data,
    output logic [15:0] red_data,
    output logic [15:0] green_data,
    output logic [15:0] blue_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_REQ, S_INIT_RSP, S_RD_REQ, S_RD_RSP, S_PUBLISH, S_WAIT, S_ERROR
    } state_t;
    state_t          state, state_nx;
    logic [2:0]      byte_idx;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   timer;
    logic [7:0]      shadow [8];
    logic            req, rsp, hs, ack, nak, retry_ok;
    assign req      = state == S_INIT_REQ || state == S_RD_REQ;
    assign rsp      = state == S_INIT_RSP || state == S_RD_RSP;
    // a stop request withdraws an unaccepted command so nothing new reaches the bus
    assign i2c_cmd_valid = req && start;
    assign hs       = i2c_cmd_valid && i2c_cmd_ready;
    assign ack      = rsp && i2c_rsp_valid && !i2c_rsp_nack;
    assign nak      = rsp && i2c_rsp_valid && i2c_rsp_nack;
    assign retry_ok = retry_cnt < RW'(MAX_RETRY);
    assign i2c_cmd_rw    = state == S_RD_REQ;
    assign i2c_cmd_addr  = req ? DEV_ADDR : 7'd0;
    assign i2c_cmd_reg   = state == S_INIT_REQ ? REG_ENABLE :
                           state == S_RD_REQ   ? REG_DATA + {5'd0, byte_idx} : 8'd0;
    assign i2c_cmd_wdata = state == S_INIT_REQ ? ENABLE_VAL : 8'd0;
    assign busy  = state != S_IDLE && state != S_ERROR;
    assign error = state == S_ERROR;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = start ? S_INIT_REQ : S_IDLE;
            S_INIT_REQ: state_nx = !start ? S_IDLE : hs ? S_INIT_RSP : S_INIT_REQ;
            S_INIT_RSP: state_nx = !i2c_rsp_valid ? S_INIT_RSP :
                                   !start         ? S_IDLE :
                                   !i2c_rsp_nack  ? S_RD_REQ :
                                   retry_ok       ? S_INIT_REQ : S_ERROR;
            S_RD_REQ:   state_nx = !start ? S_IDLE : hs ? S_RD_RSP : S_RD_REQ;
            S_RD_RSP:   state_nx = !i2c_rsp_valid ? S_RD_RSP :
                                   !start         ? S_IDLE :
                                   !i2c_rsp_nack  ? (byte_idx == 3'd7 ? S_PUBLISH : S_RD_REQ) :
                                   retry_ok       ? S_RD_REQ : S_ERROR;
            S_PUBLISH:  state_nx = start ? S_WAIT : S_IDLE;
            S_WAIT:     state_nx = !start ? S_IDLE : timer == '0 ? S_RD_REQ : S_WAIT;
            S_ERROR:    state_nx = start ? S_ERROR : S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_idx     <= '0;
            retry_cnt    <= '0;
            timer        <= '0;
            sample_valid <= 1'b0;
            clear_data   <= '0;
            red_data     <= '0;
            green_data   <= '0;
            blue_data    <= '0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else begin
            state        <= state_nx;
            sample_valid <= state == S_PUBLISH;
            if (state == S_IDLE) begin
                byte_idx  <= '0;
                retry_cnt <= '0;
            end else if (ack) begin
                retry_cnt <= '0;
                byte_idx  <= state == S_RD_RSP ? byte_idx + 3'd1 : 3'd0;
            end else if (nak && retry_ok) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (ack && state == S_RD_RSP) shadow[byte_idx] <= i2c_rsp_rdata;
            // outputs change only here, so a partial burst never leaks out; byte_idx has wrapped to 0
            if (state == S_PUBLISH) begin
                clear_data <= {shadow[1], shadow[0]};
                red_data   <= {shadow[3], shadow[2]};
                green_data <= {shadow[5], shadow[4]};
                blue_data  <= {shadow[7], shadow[6]};
                timer      <= TW'(POLL_CYCLES - 1);
            end else if (state == S_WAIT && timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end
endmodule
